// File: rtl/booth_digit_sequencer.sv
// Radix-4 Booth recoding sequencer: latches one operand pair, then emits one
// Booth digit per accepted cycle (ascending weight) toward the Dadda PP mux.
module booth_digit_sequencer #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] mcand,
  input  logic [W-1:0] mplr,
  output logic         pp_valid,
  input  logic         pp_ready,
  output logic [W:0]   pp_op,
  output logic [2:0]   pp_sel,
  output logic [2:0]   pp_idx,
  output logic         pp_neg,
  output logic         pp_last
);

  localparam int unsigned ND      = (W + 1) / 2;
  localparam logic [2:0]  LastIdx = 3'(ND - 1);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic [W-1:0]   mcand_q;
  logic [W:0]     y_q;
  logic [W+1:0]   y_ext;
  logic           is_last;
  logic           accept;

  // Append y[-1] = 0 so digit i is simply y_ext[2i+2:2i].
  assign y_ext   = {y_q, 1'b0};
  assign is_last = (state_q == StEmit) && (idx_q == LastIdx);
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      mcand_q <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        mcand_q <= mcand;
        y_q     <= {mplr[W-1], mplr};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StEmit;
          idx_d   = 3'd0;
        end
      end
      StEmit: begin
        if (pp_ready) begin
          if (!is_last) begin
            idx_d = idx_q + 3'd1;
          end else if (in_valid) begin
            // Zero-bubble restart on the final-digit handshake.
            idx_d = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    in_ready = (state_q == StIdle) || (is_last && pp_ready);
    pp_valid = 1'b0;
    pp_op    = {mcand_q[W-1], mcand_q};
    pp_sel   = 3'd0;
    pp_idx   = 3'd0;
    pp_neg   = 1'b0;
    pp_last  = 1'b0;
    if (state_q == StEmit) begin
      pp_valid = 1'b1;
      pp_sel   = y_ext[{idx_q, 1'b0} +: 3];
      pp_idx   = idx_q;
      // The mux negates by one's complement, so every negative code needs +1.
      pp_neg   = y_ext[{idx_q, 1'b0} + 4'd2];
      pp_last  = is_last;
    end
  end

endmodule

// File: doc/booth_digit_sequencer.md
# booth_digit_sequencer

Radix-4 Booth recoding sequencer that feeds the partial-product select mux of the 11-bit Dadda-tree multiplier. It accepts one multiplicand/multiplier pair through a valid/ready handshake and registers both operands. It then emits the six Booth digits, one per accepted cycle, in order of ascending weight. Each digit is presented as a 3-bit select, a digit index, a negate-correction flag and the registered multiplicand, ready to drive the mux's `fst_op`/`sel` inputs.

## Interface
- `W`, 11: operand width in bits. Must be odd. Digit count `ND = (W+1)/2` = 6 at the default.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  sequencer can accept a pair this cycle.
- `mcand`  in  W  multiplicand, two's complement.
- `mplr`  in  W  multiplier, two's complement.
- `pp_valid`  out  1  digit outputs valid.
- `pp_ready`  in  1  downstream consumes the digit this cycle.
- `pp_op`  out  W+1  registered multiplicand, sign-extended to 12 bits; drives mux `fst_op`.
- `pp_sel`  out  3  Booth triplet; drives mux `sel`.
- `pp_idx`  out  3  digit index 0..ND-1; digit weight is 4^idx.
- `pp_neg`  out  1  +1 correction at bit 2·idx, required because the mux negates by one's complement.
- `pp_last`  out  1  high when `pp_idx == ND-1`.

## Operation
- Extended multiplier: `y[W:0] = {mplr[W-1], mplr}`, with `y[-1] = 0`.
- Digit i: `pp_sel = {y[2i+1], y[2i], y[2i-1]}` for i = 0..ND-1.
- Triplet values: 000 → 0, 001 → +1, 010 → +1, 011 → +2, 100 → −2, 101 → −1, 110 → −1, 111 → −0.
- `pp_neg = pp_sel[2]`. It is 1 for 111 as well, because the mux emits all-ones for that code.
- FSM states:
  - IDLE: `pp_valid = 0`, `in_ready = 1`. On `in_valid`, latch `mcand` and `y` into internal registers, set `idx = 0` and go to EMIT.
  - EMIT: `pp_valid = 1`. On `pp_ready`: if `idx < ND-1`, increment `idx`. If `idx == ND-1` (`pp_last`), go to IDLE, unless a new pair is accepted the same cycle (see below).
- Back-to-back: `in_ready = IDLE | (EMIT & pp_last & pp_ready)`.
  - If `in_valid` is high in the final-digit handshake cycle, the new pair is latched, `idx = 0`, and the state stays EMIT. This gives zero bubble between operations.
- Backpressure: while `pp_valid & ~pp_ready`, all `pp_*` outputs hold stable and no new input is accepted.
- `pp_op`, `pp_sel`, `pp_neg`, `pp_idx` and `pp_last` are decoded from registered state only. No input-to-output combinational path exists on the `pp_*` outputs.
- Operand registers change only on an accepted input handshake.

## Timing
- Reset (`rst` low, asynchronous):
  - State IDLE.
  - `pp_valid = 0`, `pp_sel = 0`, `pp_idx = 0`, `pp_neg = 0`, `pp_last = 0`, `pp_op = 0`.
  - Operand registers cleared. `in_ready = 1`, but no capture occurs while `rst` is low.
- Reset release is synchronous to `clk`. The first capture is possible on the first rising edge with `rst` high.
- Reset asserted mid-sequence: the operation is abandoned, outputs take their reset values immediately, and no further digits of that pair are emitted.
- Latency: pair accepted at edge N → digit 0 is valid after edge N.
- With `pp_ready` held high, digit k is presented in cycle N+1+k and `pp_last` in cycle N+ND.
- Throughput: one pair per ND cycles when back-to-back.
- Simultaneous `in_valid` and `pp_ready` on a non-last digit: the input is not accepted (`in_ready = 0`).

## Test plan
- `mplr = 0`, `mcand = 11'h155`, `pp_ready` high → six digits, all `pp_sel = 000`, `pp_neg = 0`, `pp_op = 12'h155`, `pp_last` only on idx 5.
- `mplr = 11'd3` → sel sequence 110, 001, 000, 000, 000, 000; neg 1, 0, 0, 0, 0, 0.
- `mplr = 11'h7FF` (−1) → 110 then 111 ×5; `pp_neg = 1` on all six digits.
- `mplr = 11'h400` (−1024) → 000 ×5 then 110 at idx 5. `mplr = 11'd5` → 010, 010, 000, ...
- Backpressure and back-to-back:
  - Drop `pp_ready` for 3 cycles at idx 2 → outputs frozen, `in_ready = 0`.
  - Present a second pair during the idx 5 handshake → its idx 0 appears the next cycle with no gap.
- Pull `rst` low at idx 3 → `pp_valid` goes 0 asynchronously. After release, a new pair starts at idx 0 and no stale digits appear.
